// File: rtl/router_pkg.sv
// Shared router constants and the arbiter FSM state type.
package router_pkg;
  localparam int ROUTER_ADDR_W    = 2;
  localparam int ROUTER_NUM_PORTS = 4;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: one-hot grant to the first
// asserted request at or above rr_ptr, wrapping modulo NUM_REQ.
module rr_arbiter import router_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant
);

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int k);
    wrap_idx = PTR_W'((int'(base) + k) % NUM_REQ);
  endfunction

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[wrap_idx(rr_ptr, k)]) begin
        grant[wrap_idx(rr_ptr, k)] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_arbiter.sv
// Round-robin packet scheduler feeding the router's single input port.
// Optional grant statistics and forced-release flag: ROUTER_ARB_STATS_EN.
module router_arbiter import router_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  input  logic [NUM_REQ*ROUTER_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]                req_last,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [DATA_WIDTH-1:0]             din,
  output logic                              din_en,
  output logic [ROUTER_ADDR_W-1:0]          addr
`ifdef ROUTER_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]             grant_cnt,
  output logic                              force_rel
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t                 state;
  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           owner;
  logic [PTR_W-1:0]           sel;
  logic [PTR_W-1:0]           rr_ptr_nxt;
  logic [7:0]                 beat_cnt;
  logic [7:0]                 beat_cnt_nxt;
  logic [NUM_REQ-1:0]         arb_grant;
  logic [NUM_REQ-1:0]         grant;
  logic                       accept;
  logic                       sel_last;
  logic                       release_p0;
  logic [DATA_WIDTH-1:0]      din_p1;
  logic [ROUTER_ADDR_W-1:0]   addr_p1;
  logic                       vld_p1;

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    onehot_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) onehot_idx = PTR_W'(i);
    end
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant)
  );

  // While locked only the owner may move; a dropped valid becomes a bubble.
  always_comb begin
    grant = arb_grant;
    if (state == ARB_LOCKED) grant = req_valid & (NUM_REQ'(1) << owner);
  end

  assign req_ready    = grant;
  assign accept       = |grant;
  assign sel          = onehot_idx(grant);
  assign sel_last     = req_last[sel];
  assign beat_cnt_nxt = (state == ARB_LOCKED) ? beat_cnt + 8'd1 : 8'd1;
  assign release_p0   = accept && (sel_last || (beat_cnt_nxt == 8'(MAX_BURST)));
  assign rr_ptr_nxt   = (sel == PTR_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      if (release_p0) begin
        state    <= ARB_IDLE;
        rr_ptr   <= rr_ptr_nxt;
        beat_cnt <= '0;
      end else begin
        state    <= ARB_LOCKED;
        owner    <= sel;
        beat_cnt <= beat_cnt_nxt;
      end
    end
  end

  // p0 -> p1: registered router drive
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      din_p1  <= '0;
      addr_p1 <= '0;
    end else begin
      vld_p1  <= accept;
      din_p1  <= accept ? req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
      addr_p1 <= accept ? req_addr[int'(sel)*ROUTER_ADDR_W +: ROUTER_ADDR_W] : '0;
    end
  end

  assign din    = din_p1;
  assign din_en = vld_p1;
  assign addr   = addr_p1;

`ifdef ROUTER_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                  forced_p0;
  logic                  force_p1;
  logic [NUM_REQ*16-1:0] cnt_p1;

  // A beat that is itself the last one is a normal release, not a forced one.
  assign forced_p0 = accept && !sel_last && (beat_cnt_nxt == 8'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (reset) begin
      force_p1 <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      force_p1 <= forced_p0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) cnt_p1[i*16 +: 16] <= sat_inc(cnt_p1[i*16 +: 16]);
      end
    end
  end

  assign force_rel = force_p1;
  assign grant_cnt = cnt_p1;
`endif

endmodule

// File: tb/tb_router_arbiter.sv
// Directed bench for router_arbiter with a cycle-level behavioural model
// of the round-robin / packet-lock rules and hand-computed spot checks.
module tb_router_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int MB = 4;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR*2-1:0] req_addr;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [DW-1:0]   din;
  logic            din_en;
  logic [1:0]      addr;
`ifdef ROUTER_ARB_STATS_EN
  logic [NR*16-1:0] grant_cnt;
  logic             force_rel;
`endif

  logic [NR-1:0] v;
  logic [NR-1:0] l;
  logic [DW-1:0] d [NR];
  logic [1:0]    a [NR];

  int n_checks = 0;
  int n_fail   = 0;

  router_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_addr  (req_addr),
    .req_last  (req_last),
    .req_ready (req_ready),
    .din       (din),
    .din_en    (din_en),
    .addr      (addr)
`ifdef ROUTER_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .force_rel (force_rel)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign req_valid = v;
  assign req_last  = l;
  always_comb begin
    req_data = '0;
    req_addr = '0;
    for (int i = 0; i < NR; i++) begin
      req_data[i*DW +: DW] = d[i];
      req_addr[i*2 +: 2]   = a[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: arbitration rules evaluated on integers each cycle.
  bit           m_en = 0;
  bit           m_locked;
  int           m_owner, m_cnt, m_ptr;
  logic [DW-1:0] e_din;
  logic [1:0]   e_addr;
  logic         e_en;
  logic         e_force;
  int           m_gcnt [NR];

  always @(negedge clk) begin
    int win, beats;
    if (m_en) begin
      chk("model_din", din, e_din);
      chk("model_addr", {30'd0, addr}, {30'd0, e_addr});
      chk("model_din_en", {31'd0, din_en}, {31'd0, e_en});
`ifdef ROUTER_ARB_STATS_EN
      chk("model_force_rel", {31'd0, force_rel}, {31'd0, e_force});
      for (int i = 0; i < NR; i++)
        chk("model_grant_cnt", {16'd0, grant_cnt[i*16 +: 16]}, m_gcnt[i]);
`endif
    end
    if (reset) begin
      m_en = 1; m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      e_din = '0; e_addr = '0; e_en = 1'b0; e_force = 1'b0;
      for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
    end else if (m_en) begin
      win = -1;
      if (m_locked) begin
        if (v[m_owner]) win = m_owner;
      end else begin
        for (int k = 0; k < NR; k++)
          if (win < 0 && v[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
      end
      chk("model_req_ready", {28'd0, req_ready}, (win >= 0) ? (32'd1 << win) : 32'd0);
      e_force = 1'b0;
      if (win >= 0) begin
        e_din  = d[win];
        e_addr = a[win];
        e_en   = 1'b1;
        if (m_gcnt[win] < 65535) m_gcnt[win]++;
        beats  = m_locked ? m_cnt + 1 : 1;
        if (l[win] || beats == MB) begin
          e_force  = !l[win];
          m_locked = 0;
          m_ptr    = (win + 1) % NR;
          m_cnt    = 0;
        end else begin
          m_locked = 1;
          m_owner  = win;
          m_cnt    = beats;
        end
      end else begin
        e_din = '0; e_addr = '0; e_en = 1'b0;
      end
    end
  end

  task automatic clr();
    v = '0; l = '0;
    for (int i = 0; i < NR; i++) begin d[i] = '0; a[i] = '0; end
  endtask

  task automatic put(input int i, input logic [31:0] data, input logic [1:0] ad, input logic last);
    v[i] = 1'b1; d[i] = data; a[i] = ad; l[i] = last;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_din", din, 32'd0);
    chk("rst_din_en", {31'd0, din_en}, 32'd0);
    chk("rst_addr", {30'd0, addr}, 32'd0);
    cyc(); reset = 1'b0;
    @(negedge clk); chk("idle_ready", {28'd0, req_ready}, 32'd0);

    // single request
    cyc(); put(2, 32'hA5A5_0001, 2'd3, 1'b1);
    @(negedge clk); chk("single_ready", {28'd0, req_ready}, 32'b0100);
    cyc(); clr();
    @(negedge clk);
    chk("single_din", din, 32'hA5A5_0001);
    chk("single_addr", {30'd0, addr}, 32'd3);
    chk("single_en", {31'd0, din_en}, 32'd1);
    cyc();
    @(negedge clk); chk("single_en_off", {31'd0, din_en}, 32'd0);

    // fairness from rr_ptr=0
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    for (int i = 0; i < NR; i++) put(i, 32'h100 + i, 2'(i), 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fair_ready", {28'd0, req_ready}, 32'd1 << (k % 4));
      if (k > 0) begin
        chk("fair_en", {31'd0, din_en}, 32'd1);
        chk("fair_din", din, 32'h100 + ((k - 1) % 4));
      end
      cyc();
    end
    clr();

    // packet lock: move pointer to 1, then req1 3-beat packet vs req0
    put(0, 32'h200, 2'd1, 1'b1);
    @(negedge clk); chk("lock_pre", {28'd0, req_ready}, 32'b0001);
    cyc(); put(0, 32'h201, 2'd1, 1'b1); put(1, 32'h210, 2'd2, 1'b0);
    @(negedge clk); chk("lock_b1", {28'd0, req_ready}, 32'b0010);
    cyc(); put(1, 32'h211, 2'd2, 1'b0);
    @(negedge clk); chk("lock_b2", {28'd0, req_ready}, 32'b0010);
    cyc(); put(1, 32'h212, 2'd2, 1'b1);
    @(negedge clk); chk("lock_b3", {28'd0, req_ready}, 32'b0010);
    cyc(); v[1] = 1'b0;
    @(negedge clk);
    chk("lock_after", {28'd0, req_ready}, 32'b0001);
    chk("lock_b3_din", din, 32'h212);
    cyc(); clr();

    // bubble: req3 locked, drops valid for two cycles
    put(3, 32'h300, 2'd0, 1'b0); put(0, 32'h220, 2'd1, 1'b1);
    @(negedge clk); chk("bub_b1", {28'd0, req_ready}, 32'b1000);
    cyc(); v[3] = 1'b0;
    @(negedge clk); chk("bub_hold1", {28'd0, req_ready}, 32'd0);
    cyc();
    @(negedge clk);
    chk("bub_hold2", {28'd0, req_ready}, 32'd0);
    chk("bub_en1", {31'd0, din_en}, 32'd0);
    cyc(); put(3, 32'h301, 2'd0, 1'b1);
    @(negedge clk);
    chk("bub_resume", {28'd0, req_ready}, 32'b1000);
    chk("bub_en2", {31'd0, din_en}, 32'd0);
    cyc(); v[3] = 1'b0;
    @(negedge clk);
    chk("bub_then_req0", {28'd0, req_ready}, 32'b0001);
    chk("bub_b2_din", din, 32'h301);
    cyc(); clr();

    // forced release at MAX_BURST=4
    reset = 1'b1;
    cyc(); reset = 1'b0;
    put(0, 32'h400, 2'd2, 1'b0); put(1, 32'h410, 2'd3, 1'b1);
    @(negedge clk); chk("frc_b1", {28'd0, req_ready}, 32'b0001);
    cyc(); d[0] = 32'h401;
    @(negedge clk); chk("frc_b2", {28'd0, req_ready}, 32'b0001);
    cyc(); d[0] = 32'h402;
    @(negedge clk); chk("frc_b3", {28'd0, req_ready}, 32'b0001);
    cyc(); d[0] = 32'h403;
    @(negedge clk); chk("frc_b4", {28'd0, req_ready}, 32'b0001);
    cyc(); d[0] = 32'h404;
    @(negedge clk);
    chk("frc_req1", {28'd0, req_ready}, 32'b0010);
    chk("frc_b4_din", din, 32'h403);
`ifdef ROUTER_ARB_STATS_EN
    chk("frc_force_hi", {31'd0, force_rel}, 32'd1);
`endif
    cyc(); v[1] = 1'b0;
    @(negedge clk);
    chk("frc_b5", {28'd0, req_ready}, 32'b0001);
    chk("frc_req1_din", din, 32'h410);
`ifdef ROUTER_ARB_STATS_EN
    chk("frc_force_lo", {31'd0, force_rel}, 32'd0);
`endif
    cyc(); d[0] = 32'h405; l[0] = 1'b1;
    @(negedge clk); chk("frc_b6", {28'd0, req_ready}, 32'b0001);
    cyc(); clr();
    @(negedge clk);
    chk("frc_b6_din", din, 32'h405);
`ifdef ROUTER_ARB_STATS_EN
    chk("stat_req0", {16'd0, grant_cnt[15:0]}, 32'd6);
    chk("stat_req1", {16'd0, grant_cnt[31:16]}, 32'd1);
`endif

    // reset during beat 2 of a packet from req2
    cyc(); put(2, 32'h500, 2'd2, 1'b0);
    @(negedge clk); chk("mid_b1", {28'd0, req_ready}, 32'b0100);
    cyc(); d[2] = 32'h501; reset = 1'b1;
    @(negedge clk);
    cyc(); reset = 1'b0; d[2] = 32'h500; put(0, 32'h510, 2'd1, 1'b1);
    @(negedge clk);
    chk("mid_rst_din", din, 32'd0);
    chk("mid_rst_en", {31'd0, din_en}, 32'd0);
    chk("mid_rst_addr", {30'd0, addr}, 32'd0);
    chk("mid_ptr0", {28'd0, req_ready}, 32'b0001);
    cyc(); v[0] = 1'b0;
    @(negedge clk);
    chk("mid_restart", {28'd0, req_ready}, 32'b0100);
    chk("mid_req0_din", din, 32'h510);
    cyc(); clr();
    repeat (3) cyc();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
